qdiv_rr_sched: RTL and testbench

- Round-robin scheduler that shares one serial fixed-point divider (qdiv, sign-magnitude (Q,N) format) between NREQ requesters.
- Accepts one operand pair at a time, detects divide-by-zero, sequences the divider's start/complete handshake and returns the result tagged with the requester ID.
- Sits between the datapath stages that need division and the single divider instance.

---
 rtl/qdiv_rr_sched_pkg.sv | 18 +
 rtl/qdiv.sv | 77 +++++++
 rtl/qdiv_rr_sched_rr_grant.sv | 44 ++++
 rtl/qdiv_rr_sched.sv | 181 ++++++++++++++++++
 tb/tb_qdiv_rr_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qdiv_rr_sched_pkg.sv
// qdiv_rr_sched_pkg
// Shared definitions for the round-robin divider scheduler:
//   state_t     - scheduler FSM state encoding (3 bits)
//   DZ_SAT_MAG  - magnitude pattern returned on divide-by-zero (all ones,
//                 sliced to N-1 bits by the user)
package qdiv_rr_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [63:0] DZ_SAT_MAG = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/qdiv.sv
// qdiv
// Serial sign-magnitude fixed-point divider, one quotient bit per clock.
// The quotient is floor((|dividend| << Q) / |divisor|) with the sign
// being the XOR of the operand signs.
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        start pulse, honoured only while idle (o_complete==1)
//   i_dividend     dividend, (Q,N) sign-magnitude
//   i_divisor      divisor,  (Q,N) sign-magnitude, magnitude must be non-zero
//   o_quotient_out quotient, valid while o_complete==1
//   o_complete     1 when idle / result ready, 0 while dividing
//   o_overflow     quotient magnitude does not fit in N-1 bits
module qdiv #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int DW = N - 1 + Q;
    localparam int CW = $clog2(DW + 1);

    // r_work starts as the scaled dividend and fills up with quotient bits
    // from the right as the dividend bits are shifted out on the left.
    logic [DW-1:0] r_work;
    logic [N-1:0]  r_rem;
    logic [N-2:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_sign;
    logic          r_done;

    logic [N-1:0]  w_shift;
    logic [N-1:0]  w_trial;
    logic          w_fits;

    assign w_shift = {r_rem[N-2:0], r_work[DW-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    assign w_fits  = (w_shift >= {1'b0, r_dvs});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_work <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_done <= 1'b1;
        end else if (i_start && r_done) begin
            r_work <= {i_dividend[N-2:0], {Q{1'b0}}};
            r_rem  <= '0;
            r_dvs  <= i_divisor[N-2:0];
            r_sign <= i_dividend[N-1] ^ i_divisor[N-1];
            r_cnt  <= CW'(DW);
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_rem  <= w_fits ? w_trial : w_shift;
            r_work <= {r_work[DW-2:0], w_fits};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_quotient_out = {r_sign, r_work[N-2:0]};
    assign o_overflow     = |r_work[DW-1:N-1];
    assign o_complete     = r_done;

endmodule

// File: rtl/qdiv_rr_sched_rr_grant.sv
// rr_grant
// Combinational round-robin arbiter: picks the first asserted request
// searching upward from i_last+1 with wrap-around.
// Ports:
//   i_req   request vector
//   i_last  index granted most recently
//   o_gnt   one-hot grant
//   o_idx   binary index of the grant
//   o_any   at least one request is asserted
module rr_grant
    import qdiv_rr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] v_idx;

    // Walk from the farthest candidate to the nearest so the nearest
    // asserted request after i_last is the one left standing.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        v_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            v_idx = IDW'((int'(i_last) + i) % NREQ);
            if (i_req[v_idx]) begin
                o_idx = v_idx;
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/qdiv_rr_sched.sv
// qdiv_rr_sched
// Shares one serial qdiv divider between NREQ requesters in round-robin
// order and returns each result tagged with the owning requester ID.
// Ports:
//   i_clk         clock
//   rst           synchronous active-low reset
//   req_valid     per-requester operand valid
//   req_ready     one-hot grant, only ever asserted in IDLE
//   req_dividend  packed dividends, requester k at [k*N +: N]
//   req_divisor   packed divisors, same packing
//   rsp_valid     result valid, payload held until rsp_ready
//   rsp_ready     result accepted
//   rsp_id        requester owning the result
//   rsp_quotient  quotient
//   rsp_overflow  divider overflow or divide-by-zero
//   rsp_divzero   divisor magnitude was zero
//   busy          high in every state except IDLE
//
// state     | meaning
// S_IDLE    | arbitrate, latch operands of the granted requester
// S_START   | one-cycle start pulse to the divider
// S_WAIT_LO | wait for the divider to drop o_complete
// S_WAIT_HI | wait for the divider to raise o_complete, capture result
// S_RESP    | present result until rsp_ready
module qdiv_rr_sched
    import qdiv_rr_sched_pkg::*;
#(
    parameter int Q    = 15,
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            i_clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [N-1:0]    rsp_quotient,
    output logic            rsp_overflow,
    output logic            rsp_divzero,
    output logic            busy
);

    state_t         r_state;
    logic [IDW-1:0] r_last;
    logic [N-1:0]   r_dvd;
    logic [N-1:0]   r_dvs;
    logic           r_div_start;
    logic           r_rsp_valid;
    logic           r_busy;
    logic [IDW-1:0] r_rsp_id;
    logic [N-1:0]   r_rsp_quot;
    logic           r_rsp_ov;
    logic           r_rsp_dz;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic [N-1:0]    w_sel_dvd;
    logic [N-1:0]    w_sel_dvs;
    logic [N-1:0]    w_div_quot;
    logic            w_div_ov;
    logic            w_div_done;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    qdiv #(
        .Q (Q),
        .N (N)
    ) u_qdiv (
        .i_clk          (i_clk),
        .i_rst          (!rst),
        .i_start        (r_div_start),
        .i_dividend     (r_dvd),
        .i_divisor      (r_dvs),
        .o_quotient_out (w_div_quot),
        .o_complete     (w_div_done),
        .o_overflow     (w_div_ov)
    );

    assign w_sel_dvd = req_dividend[int'(w_idx)*N +: N];
    assign w_sel_dvs = req_divisor[int'(w_idx)*N +: N];

    // Gated with rst so no requester sees an accept during the reset cycle.
    assign req_ready = (rst && (r_state == S_IDLE)) ? w_gnt : '0;

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_div_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_quot  <= '0;
            r_rsp_ov    <= 1'b0;
            r_rsp_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_last   <= w_idx;
                        r_dvd    <= w_sel_dvd;
                        r_dvs    <= w_sel_dvs;
                        r_rsp_id <= w_idx;
                        r_busy   <= 1'b1;
                        // Zero divisor magnitude is answered directly;
                        // the divider is never started for it.
                        if (w_sel_dvs[N-2:0] == '0) begin
                            r_rsp_quot  <= {w_sel_dvd[N-1] ^ w_sel_dvs[N-1],
                                            DZ_SAT_MAG[N-2:0]};
                            r_rsp_ov    <= 1'b1;
                            r_rsp_dz    <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_div_start <= 1'b0;
                    r_state     <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    // o_complete is still high from the previous run until
                    // the divider has taken the start; do not trust it yet.
                    if (!w_div_done) begin
                        r_state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (w_div_done) begin
                        r_rsp_quot  <= w_div_quot;
                        r_rsp_ov    <= w_div_ov;
                        r_rsp_dz    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_div_start <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_quotient = r_rsp_quot;
    assign rsp_overflow = r_rsp_ov;
    assign rsp_divzero  = r_rsp_dz;
    assign busy         = r_busy;

endmodule

// File: tb/tb_qdiv_rr_sched.sv
// tb_qdiv_rr_sched
// Scoreboard bench for qdiv_rr_sched: grants are predicted by a round-robin
// model and each grant pushes the arithmetically computed result; a monitor
// pops and compares on every response handshake.
module tb_qdiv_rr_sched;

    localparam int Q    = 15;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 i_clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_dividend;
    logic [NREQ*N-1:0]    req_divisor;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [N-1:0]         rsp_quotient;
    logic                 rsp_overflow;
    logic                 rsp_divzero;
    logic                 busy;

    logic [31:0] opa [NREQ];
    logic [31:0] opb [NREQ];

    qdiv_rr_sched #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk        (i_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_overflow (rsp_overflow),
        .rsp_divzero  (rsp_divzero),
        .busy         (busy)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        req_dividend = '0;
        req_divisor  = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_dividend[k*N +: N] = opa[k];
            req_divisor[k*N +: N]  = opb[k];
        end
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] q;
        logic        ov;
        logic        dz;
        int          rise;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   errors = 0;
    int   checks = 0;
    int   m_last = NREQ - 1;
    int   exp_starts = 0;
    int   seen_starts = 0;

    logic [31:0] last_q;
    logic [31:0] last_id;
    logic        last_ov;
    logic        last_dz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Plain arithmetic reference: |a| * 2^Q / |b|, sign = XOR of signs.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic ov, output logic dz);
        longint unsigned am, bm, qq;
        am = {33'd0, a[30:0]};
        bm = {33'd0, b[30:0]};
        if (bm == 0) begin
            q  = {a[31] ^ b[31], 31'h7FFF_FFFF};
            ov = 1'b1;
            dz = 1'b1;
        end else begin
            qq = (am << Q) / bm;
            ov = (qq > 64'h7FFF_FFFF);
            dz = 1'b0;
            q  = {a[31] ^ b[31], qq[30:0]};
        end
    endfunction

    // Response monitor.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_q;
    logic [31:0] prev_id;
    logic        prev_ov, prev_dz;
    exp_t        me;

    always @(negedge i_clk) begin
        if (dut.r_div_start) seen_starts++;
        if (rst) begin
            if (busy) chk("req_ready_while_busy", 32'(req_ready), 32'd0);
            if (rsp_valid && !prev_valid && sb.size() > 0 && sb[0].rise >= 0)
                chk("divzero_latency_cycle", cyc, sb[0].rise);
            if (rsp_valid && prev_valid && !prev_ready) begin
                chk("hold_quot", rsp_quotient, prev_q);
                chk("hold_id", 32'(rsp_id), prev_id);
                chk("hold_flags", {30'd0, rsp_overflow, rsp_divzero}, {30'd0, prev_ov, prev_dz});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d with empty scoreboard", rsp_id);
                end else begin
                    me = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(me.id));
                    chk("rsp_quotient", rsp_quotient, me.q);
                    chk("rsp_overflow", 32'(rsp_overflow), 32'(me.ov));
                    chk("rsp_divzero", 32'(rsp_divzero), 32'(me.dz));
                end
                last_q  = rsp_quotient;
                last_id = 32'(rsp_id);
                last_ov = rsp_overflow;
                last_dz = rsp_divzero;
            end
        end
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;
        prev_q     = rsp_quotient;
        prev_id    = 32'(rsp_id);
        prev_ov    = rsp_overflow;
        prev_dz    = rsp_divzero;
    end

    task automatic new_op(input int k);
        logic [31:0] m;
        case ($urandom_range(0, 2))
            0:       m = 32'h7FFF_FFFF;
            1:       m = 32'h00FF_FFFF;
            default: m = 32'h0001_FFFF;
        endcase
        opa[k] = $urandom & m;
        opa[k][31] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) begin
            opb[k] = 32'd0;
        end else begin
            case ($urandom_range(0, 2))
                0:       m = 32'h7FFF_FFFF;
                1:       m = 32'h000F_FFFF;
                default: m = 32'h0000_FFFF;
            endcase
            opb[k] = $urandom & m;
            if (opb[k] == 32'd0) opb[k] = 32'd1;
        end
        opb[k][31] = 1'($urandom_range(0, 1));
        req_valid[k] = 1'b1;
    endtask

    // One clock: predict/check any grant, then update requester inputs.
    task automatic step(input bit rand_mode);
        int          g;
        int          e;
        logic [NREQ-1:0] ev;
        exp_t        x;
        g = -1;
        @(negedge i_clk);
        if (rst && (req_ready != '0 || (!busy && req_valid != '0))) begin
            e  = rr_pick(req_valid, m_last);
            ev = '0;
            if (e >= 0) ev[e] = 1'b1;
            chk("grant_onehot", 32'(req_ready), 32'(ev));
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
            if (e >= 0) begin
                x.id = e;
                ref_div(opa[e], opb[e], x.q, x.ov, x.dz);
                x.rise = x.dz ? cyc + 1 : -1;
                if (!x.dz) exp_starts++;
                sb.push_back(x);
                m_last = e;
            end
            if (g >= 0) glog.push_back(g);
        end
        @(posedge i_clk);
        #1;
        if (g >= 0) begin
            req_valid[g] = 1'b0;
            if (rand_mode && $urandom_range(0, 1) == 1) new_op(g);
        end
        if (rand_mode) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++)
                if (!req_valid[k] && $urandom_range(0, 7) == 0) new_op(k);
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 2000; i++) begin
            if (req_valid == '0 && sb.size() == 0 && !busy && !rsp_valid) break;
            step(1'b0);
        end
        if (i == 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending %0d expected 0", sb.size());
        end
    endtask

    task automatic do_reset(input logic [NREQ-1:0] v);
        rst = 1'b0;
        req_valid = v;
        sb.delete();
        m_last = NREQ - 1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_quotient", rsp_quotient, 32'd0);
        chk("rst_flags", {30'd0, rsp_overflow, rsp_divzero}, 32'd0);
        @(posedge i_clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_order(input string name, input int pos, input int exp);
        chk(name, (glog.size() > pos) ? 32'(glog[pos]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    initial begin
        int s0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int k = 0; k < NREQ; k++) begin
            opa[k] = 32'd0;
            opb[k] = 32'd0;
        end

        // 3.0 / 2.0 on requester 0
        opa[0] = 32'h0001_8000;
        opb[0] = 32'h0001_0000;
        do_reset(4'b0001);
        drain();
        chk("t1_id", last_id, 32'd0);
        chk("t1_quot", last_q, 32'h0000_C000);
        chk("t1_flags", {30'd0, last_ov, last_dz}, 32'd0);

        // negative dividend on requester 2
        opa[2] = 32'h8001_8000;
        opb[2] = 32'h0001_0000;
        req_valid = 4'b0100;
        drain();
        chk("t2_id", last_id, 32'd2);
        chk("t2_quot", last_q, 32'h8000_C000);

        // divide by negative zero on requester 1
        opa[1] = 32'h0001_8000;
        opb[1] = 32'h8000_0000;
        s0 = seen_starts;
        req_valid = 4'b0010;
        drain();
        chk("t3_id", last_id, 32'd1);
        chk("t3_quot", last_q, 32'hFFFF_FFFF);
        chk("t3_flags", {30'd0, last_ov, last_dz}, 32'd3);
        chk("t3_no_div_start", 32'(seen_starts), 32'(s0));

        // fairness from reset with everyone requesting
        for (int k = 0; k < NREQ; k++) begin
            opa[k] = 32'(k + 1) << 16;
            opb[k] = 32'h0001_0000;
        end
        glog.delete();
        do_reset(4'b1111);
        drain();
        for (int i = 0; i < NREQ; i++) chk_order("fair_order", i, i);

        // last=1, then requesters 0 and 3: 3 must win first
        req_valid = 4'b0010;
        drain();
        glog.delete();
        req_valid = 4'b1001;
        drain();
        chk_order("wrap_first", 0, 3);
        chk_order("wrap_second", 1, 0);

        // backpressure: hold rsp_ready low for 10 cycles with others waiting
        rsp_ready = 1'b0;
        req_valid = 4'b0101;
        for (int i = 0; i < 200 && !rsp_valid; i++) step(1'b0);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL bp_wait_timeout: got rsp_valid 0 expected 1");
        end
        repeat (10) step(1'b0);
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        chk("bp_id", 32'(rsp_id), 32'd2);
        rsp_ready = 1'b1;
        drain();

        // reset in the middle of a division
        req_valid = 4'b0010;
        repeat (12) step(1'b0);
        rst = 1'b0;
        sb.delete();
        m_last = NREQ - 1;
        step(1'b0);
        rst = 1'b1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        glog.delete();
        req_valid = 4'b1111;
        drain();
        chk_order("midrst_first_grant", 0, 0);

        // random traffic with random backpressure
        for (int k = 0; k < NREQ; k++) new_op(k);
        repeat (3000) step(1'b1);
        rsp_ready = 1'b1;
        drain();

        chk("div_start_count", 32'(seen_starts), 32'(exp_starts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
